// File: rtl/prefetch_arbiter_if.sv
// prefetch_arbiter_if: demand, prefetch and memory-side handshake bundle for prefetch_arbiter.
// slave is the arbiter side; master is the requester/memory environment side.
interface prefetch_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              dmdValid;
    logic [ADDR_W-1:0] dmdAddr;
    logic              dmdReady;
    logic              pfValid;
    logic [ADDR_W-1:0] pfAddr;
    logic              pfDrop;
    logic              memValid;
    logic [ADDR_W-1:0] memAddr;
    logic              memIsPf;
    logic              memReady;
    logic              memDone;
    logic [7:0]        dropCount;

    modport slave (
        input  dmdValid, dmdAddr, pfValid, pfAddr, memReady, memDone,
        output dmdReady, pfDrop, memValid, memAddr, memIsPf, dropCount
    );

    modport master (
        output dmdValid, dmdAddr, pfValid, pfAddr, memReady, memDone,
        input  dmdReady, pfDrop, memValid, memAddr, memIsPf, dropCount
    );
endinterface

// File: rtl/prefetch_arbiter.sv
// prefetch_arbiter: puts demand and queued prefetch requests onto a single-outstanding memory port.
// Define PF_DEDUP_EN to drop prefetches that duplicate a queued or outstanding address.
module prefetch_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    prefetch_arbiter_if.slave bus
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned DROP_MAX = 255;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e            state_q, state_d;

    logic [ADDR_W-1:0] q_addr_q [DEPTH];
    logic [ADDR_W-1:0] q_addr_d [DEPTH];
    logic [DEPTH-1:0]  q_vld_q, q_vld_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_is_pf_q, mem_is_pf_d;
    logic              dmd_ready_q, dmd_ready_d;
    logic              pf_drop_q, pf_drop_d;
    logic [7:0]        drop_count_q, drop_count_d;

    logic dmd_acc;
    logic pop;
    logic pop_vld;
    logic q_full;
    logic dup;
    logic push;

    // Demand always wins; the queue head is only popped in IDLE with no demand present.
    assign dmd_acc = (state_q == S_IDLE) && bus.dmdValid;
    assign pop     = (state_q == S_IDLE) && !bus.dmdValid && (count_q != '0);
    assign pop_vld = pop && q_vld_q[rd_ptr_q];
    assign q_full  = (count_q == CNT_W'(DEPTH));
    assign push    = bus.pfValid && !dup && (!q_full || pop);

`ifdef PF_DEDUP_EN
    // A queued valid entry or the outstanding request already covers this address.
    always_comb begin
        dup = (state_q != S_IDLE) && (mem_addr_q == bus.pfAddr);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (q_vld_q[i] && (q_addr_q[i] == bus.pfAddr)) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dmd_acc || pop_vld) state_d = S_ISSUE;
            S_ISSUE: if (bus.memReady)       state_d = S_WAIT;
            S_WAIT:  if (bus.memDone)        state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // Registered outputs follow the next state; address/type latch only when a request starts.
    always_comb begin
        mem_valid_d  = (state_d == S_ISSUE);
        dmd_ready_d  = (state_d == S_IDLE);
        mem_addr_d   = mem_addr_q;
        mem_is_pf_d  = mem_is_pf_q;
        pf_drop_d    = bus.pfValid && !push;
        drop_count_d = drop_count_q;
        if (dmd_acc) begin
            mem_addr_d  = bus.dmdAddr;
            mem_is_pf_d = 1'b0;
        end else if (pop_vld) begin
            mem_addr_d  = q_addr_q[rd_ptr_q];
            mem_is_pf_d = 1'b1;
        end
        if (pf_drop_d && (drop_count_q != 8'(DROP_MAX))) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Pop clears the head before push so a full queue can pop and push the same slot.
    always_comb begin
        q_addr_d = q_addr_q;
        q_vld_d  = q_vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            q_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (dmd_acc) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (q_addr_q[i] == bus.dmdAddr) begin
                    q_vld_d[i] = 1'b0;
                end
            end
        end
        if (push) begin
            q_addr_d[wr_ptr_q] = bus.pfAddr;
            q_vld_d[wr_ptr_q]  = !(dmd_acc && (bus.pfAddr == bus.dmdAddr));
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_addr_q[i] <= '0;
            end
            q_vld_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_is_pf_q  <= 1'b0;
            dmd_ready_q  <= 1'b1;
            pf_drop_q    <= 1'b0;
            drop_count_q <= '0;
        end else begin
            q_addr_q     <= q_addr_d;
            q_vld_q      <= q_vld_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_is_pf_q  <= mem_is_pf_d;
            dmd_ready_q  <= dmd_ready_d;
            pf_drop_q    <= pf_drop_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bus.dmdReady  = dmd_ready_q;
    assign bus.memValid  = mem_valid_q;
    assign bus.memAddr   = mem_addr_q;
    assign bus.memIsPf   = mem_is_pf_q;
    assign bus.pfDrop    = pf_drop_q;
    assign bus.dropCount = drop_count_q;
endmodule

// File: tb/tb_prefetch_arbiter.sv
// tb_prefetch_arbiter: scoreboard bench for prefetch_arbiter; a queue-based reference model
// predicts per-cycle status and the order of memory requests, a negedge monitor compares.
module tb_prefetch_arbiter;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 16;
    localparam int PH_IDLE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_WAIT  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              is_pf;
    } req_t;

    typedef struct packed {
        logic       dr;
        logic       mv;
        logic       pd;
        logic [7:0] dc;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n;

    prefetch_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    prefetch_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          in_reset = 1'b1;

    cyc_t chk_q[$];
    req_t exp_mem_q[$];

    // Reference model: prefetch queue as parallel address/valid queues plus request phase.
    int                m_phase = PH_IDLE;
    logic [ADDR_W-1:0] m_addr[$];
    bit                m_vld[$];
    logic [ADDR_W-1:0] m_cur   = '0;
    int                m_drops = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Monitor: per-cycle status and, on each memory handshake, the next expected request.
    always @(negedge clk) begin
        cyc_t e;
        req_t r;
        if (!in_reset && chk_q.size() > 0) begin
            e = chk_q.pop_front();
            check("dmdReady",  32'(bus.dmdReady),  32'(e.dr));
            check("memValid",  32'(bus.memValid),  32'(e.mv));
            check("pfDrop",    32'(bus.pfDrop),    32'(e.pd));
            check("dropCount", 32'(bus.dropCount), 32'(e.dc));
        end
        if (!in_reset && bus.memValid && bus.memReady) begin
            if (exp_mem_q.size() == 0) begin
                check("unexpected_mem_req", 32'(bus.memAddr), 32'hFFFF_FFFF);
            end else begin
                r = exp_mem_q.pop_front();
                check("memAddr", 32'(bus.memAddr), 32'(r.addr));
                check("memIsPf", 32'(bus.memIsPf), 32'(r.is_pf));
            end
        end
    end

    // Drive one cycle of inputs, advance the model, and post its expectations after the edge.
    task automatic cycle(input logic dv, input logic [ADDR_W-1:0] da, input logic pv,
                         input logic [ADDR_W-1:0] pa, input logic mr, input logic md);
        bit dacc, pop, dup, push, drop, issue, pop_v;
        logic [ADDR_W-1:0] pop_a;
        req_t rq;
        cyc_t ce;
        bus.dmdValid = dv;
        bus.dmdAddr  = da;
        bus.pfValid  = pv;
        bus.pfAddr   = pa;
        bus.memReady = mr;
        bus.memDone  = md;
        dacc  = (m_phase == PH_IDLE) && dv;
        pop   = (m_phase == PH_IDLE) && !dv && (m_addr.size() > 0);
        dup   = 1'b0;
        issue = 1'b0;
        rq    = '0;
`ifdef PF_DEDUP_EN
        foreach (m_addr[i]) if (m_vld[i] && m_addr[i] == pa) dup = 1'b1;
        if (m_phase != PH_IDLE && m_cur == pa) dup = 1'b1;
`endif
        push = pv && !dup && ((m_addr.size() < int'(DEPTH)) || pop);
        drop = pv && !push;
        if (m_phase == PH_IDLE) begin
            if (dacc) begin
                issue = 1'b1; rq.addr = da; rq.is_pf = 1'b0;
            end else if (pop) begin
                pop_a = m_addr.pop_front();
                pop_v = m_vld.pop_front();
                if (pop_v) begin
                    issue = 1'b1; rq.addr = pop_a; rq.is_pf = 1'b1;
                end
            end
        end else if (m_phase == PH_ISSUE) begin
            if (mr) m_phase = PH_WAIT;
        end else begin
            if (md) m_phase = PH_IDLE;
        end
        if (issue) begin
            m_phase = PH_ISSUE;
            m_cur   = rq.addr;
        end
        if (dacc) foreach (m_addr[i]) if (m_addr[i] == da) m_vld[i] = 1'b0;
        if (push) begin
            m_addr.push_back(pa);
            m_vld.push_back(!(dacc && pa == da));
        end
        if (drop && m_drops < 255) m_drops++;
        ce.dr = (m_phase == PH_IDLE);
        ce.mv = (m_phase == PH_ISSUE);
        ce.pd = drop;
        ce.dc = 8'(m_drops);
        @(posedge clk);
        chk_q.push_back(ce);
        if (issue) exp_mem_q.push_back(rq);
        #1;
    endtask

    task automatic idle_cycle(input logic mr, input logic md);
        cycle(1'b0, '0, 1'b0, '0, mr, md);
    endtask

    task automatic do_reset(input int cycles);
        in_reset = 1'b1;
        chk_q.delete();
        exp_mem_q.delete();
        bus.dmdValid = 1'b0; bus.dmdAddr = '0; bus.pfValid = 1'b0;
        bus.pfAddr = '0; bus.memReady = 1'b0; bus.memDone = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_memValid",  32'(bus.memValid),  32'd0);
        check("rst_memAddr",   32'(bus.memAddr),   32'd0);
        check("rst_memIsPf",   32'(bus.memIsPf),   32'd0);
        check("rst_pfDrop",    32'(bus.pfDrop),    32'd0);
        check("rst_dropCount", 32'(bus.dropCount), 32'd0);
        m_phase = PH_IDLE;
        m_addr.delete();
        m_vld.delete();
        m_cur   = '0;
        m_drops = 0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_dmdReady", 32'(bus.dmdReady), 32'd1);
        in_reset = 1'b0;
    endtask

    // Retire the outstanding request and empty the queue; bounded by the model's own progress.
    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (m_phase == PH_IDLE && m_addr.size() == 0) break;
            idle_cycle(1'b1, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic              r_dv, r_pv, r_mr, r_md;
        logic [ADDR_W-1:0] r_da, r_pa;
        bus.dmdValid = 1'b0; bus.dmdAddr = '0; bus.pfValid = 1'b0;
        bus.pfAddr = '0; bus.memReady = 1'b0; bus.memDone = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_reset(3);

        // Demand 0x1234: valid next cycle, then WAIT on memReady, IDLE on memDone.
        cycle(1'b1, 16'h1234, 1'b0, '0, 1'b0, 1'b0);
        check("d_dmd_valid", 32'(bus.memValid), 32'd1);
        check("d_dmd_addr",  32'(bus.memAddr),  32'h1234);
        check("d_dmd_ispf",  32'(bus.memIsPf),  32'd0);
        idle_cycle(1'b1, 1'b0);
        check("d_wait_valid", 32'(bus.memValid), 32'd0);
        check("d_wait_ready", 32'(bus.dmdReady), 32'd0);
        idle_cycle(1'b0, 1'b1);
        check("d_idle_ready", 32'(bus.dmdReady), 32'd1);

        // Two prefetches while idle, issued in order.
        cycle(1'b0, '0, 1'b1, 16'h0100, 1'b0, 1'b0);
        check("d_pf_enq_novalid", 32'(bus.memValid), 32'd0);
        cycle(1'b0, '0, 1'b1, 16'h0104, 1'b0, 1'b0);
        check("d_pf0_addr", 32'(bus.memAddr), 32'h0100);
        check("d_pf0_ispf", 32'(bus.memIsPf), 32'd1);
        idle_cycle(1'b1, 1'b0);
        idle_cycle(1'b0, 1'b1);
        idle_cycle(1'b0, 1'b0);
        check("d_pf1_addr", 32'(bus.memAddr), 32'h0104);
        check("d_pf1_ispf", 32'(bus.memIsPf), 32'd1);
        idle_cycle(1'b1, 1'b0);
        idle_cycle(1'b0, 1'b1);

        // Full queue drops without a pop, accepts with one.
        cycle(1'b1, 16'h1234, 1'b0, '0, 1'b0, 1'b0);
        idle_cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 16'h0500 + 16'(i * 4), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 16'h0200, 1'b0, 1'b0);
        check("d_full_drop",  32'(bus.pfDrop),    32'd1);
        check("d_full_count", 32'(bus.dropCount), 32'd1);
        idle_cycle(1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 16'h0200, 1'b0, 1'b0);
        check("d_fullpop_nodrop", 32'(bus.pfDrop),    32'd0);
        check("d_fullpop_count",  32'(bus.dropCount), 32'd1);
        drain();

        // Demand squashes a queued prefetch of the same address.
        cycle(1'b1, 16'h1000, 1'b0, '0, 1'b0, 1'b0);
        idle_cycle(1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 16'h0300, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b1);
        cycle(1'b1, 16'h0300, 1'b0, '0, 1'b0, 1'b0);
        check("d_sq_dmd_ispf", 32'(bus.memIsPf), 32'd0);
        idle_cycle(1'b1, 1'b0);
        idle_cycle(1'b0, 1'b1);
        idle_cycle(1'b0, 1'b0);
        check("d_sq_novalid", 32'(bus.memValid), 32'd0);
        check("d_sq_ready",   32'(bus.dmdReady), 32'd1);
        drain();

        // Duplicate prefetch address.
        cycle(1'b1, 16'h1100, 1'b0, '0, 1'b0, 1'b0);
        idle_cycle(1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 16'h0400, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 16'h0400, 1'b0, 1'b0);
`ifdef PF_DEDUP_EN
        check("d_dup_drop", 32'(bus.pfDrop), 32'd1);
`else
        check("d_dup_drop", 32'(bus.pfDrop), 32'd0);
`endif
        drain();

        // Reset while issuing with queued entries and a nonzero drop count.
        cycle(1'b0, '0, 1'b1, 16'h0700, 1'b0, 1'b0);
        cycle(1'b1, 16'h2000, 1'b1, 16'h0600, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 16'h0604, 1'b0, 1'b0);
        check("d_pre_rst_valid", 32'(bus.memValid), 32'd1);
        do_reset(2);
        idle_cycle(1'b0, 1'b1);
        idle_cycle(1'b1, 1'b0);
        idle_cycle(1'b0, 1'b0);
        check("d_post_rst_novalid", 32'(bus.memValid), 32'd0);

        // Randomized traffic over a small address set to exercise squash, dedup and full.
        for (int n = 0; n < 2500; n++) begin
            r_dv = ($urandom_range(0, 99) < 15);
            r_da = 16'h0100 + 16'($urandom_range(0, 7) * 4);
            r_pv = ($urandom_range(0, 99) < 55);
            r_pa = 16'h0100 + 16'($urandom_range(0, 7) * 4);
            r_mr = ($urandom_range(0, 99) < 50);
            r_md = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 599) == 0) do_reset(2);
            cycle(r_dv, r_da, r_pv, r_pa, r_mr, r_md);
        end
        drain();
        idle_cycle(1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("end_mem_q_empty", 32'(exp_mem_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prefetch_arbiter.md
PREFETCH_ARBITER -- requirements
Module: prefetch_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port dmdValid, input, 1, demand access request.
REQ-006 SHALL have port dmdAddr, input, ADDR_W, demand address.
REQ-007 SHALL have port dmdReady, output, 1, demand accepted when dmdValid&&dmdReady.
REQ-008 SHALL have port pfValid, input, 1, prefetch request from prefetcher memRequest.
REQ-009 SHALL have port pfAddr, input, ADDR_W, prefetch address from prefetcher requestAddress.
REQ-010 SHALL have port pfDrop, output, 1, one-cycle pulse when an offered prefetch is discarded.
REQ-011 SHALL have port memValid, output, 1, memory request valid.
REQ-012 SHALL have port memAddr, output, ADDR_W, memory request address.
REQ-013 SHALL have port memIsPf, output, 1, current memory request is a prefetch.
REQ-014 SHALL have port memReady, input, 1, memory accepts request when memValid&&memReady.
REQ-015 SHALL have port memDone, input, 1, one-cycle pulse: outstanding request complete.
REQ-016 SHALL have port dropCount, output, 8, saturating count of discarded prefetches.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT; one memory request outstanding at most.
REQ-018 SHALL drive dmdReady=1 only in IDLE; demand always wins over queued prefetch.
REQ-019 In IDLE with demand handshake SHALL latch dmdAddr, memIsPf=0, enter ISSUE next cycle.
REQ-020 In IDLE, no dmdValid, queue non-empty: SHALL pop head; valid entry -> latch addr, memIsPf=1, ISSUE; invalidated entry -> discard, stay IDLE.
REQ-021 In ISSUE SHALL hold memValid=1, memAddr/memIsPf stable until memReady; then WAIT.
REQ-022 In WAIT SHALL hold memValid=0 and return to IDLE on memDone; memDone outside WAIT ignored.
REQ-023 Latency: demand accepted in cycle N -> memValid=1 in cycle N+1.
REQ-024 Queue SHALL be FIFO with per-entry valid bit, wrap-around read/write pointers, occupancy 0..DEPTH.
REQ-025 pfValid with queue full and no pop that cycle SHALL drop the request (pfDrop=1).
REQ-026 pfValid with queue full and pop same cycle SHALL accept the push.
REQ-027 pfValid with queue empty and IDLE-pop condition SHALL enqueue, not bypass; issue earliest next cycle.
REQ-028 On demand accept SHALL clear valid bit of every queue entry whose address equals dmdAddr, including an entry pushed same cycle.
REQ-029 dropCount SHALL increment per pfDrop pulse and saturate at 255.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, queue empty, pointers 0, all valid bits 0.
REQ-031 During/after reset outputs SHALL be memValid=0, memAddr=0, memIsPf=0, pfDrop=0, dropCount=0, dmdReady=1 once rst_n high.
REQ-032 Reset mid-ISSUE/WAIT SHALL abandon outstanding request; later memDone in IDLE ignored.

Configuration
REQ-033 Macro PF_DEDUP_EN defined: pfValid whose address matches a valid queue entry or the outstanding memAddr SHALL be dropped (pfDrop=1).
REQ-034 PF_DEDUP_EN undefined: no duplicate check; prefetches dropped only when full per REQ-025.

Verification
REQ-035 dmdValid=1, dmdAddr=0x1234 in IDLE at cycle 0 -> cycle 1 memValid=1, memAddr=0x1234, memIsPf=0; memReady -> WAIT; memDone -> IDLE.
REQ-036 Push 0x0100,0x0104 while idle, no demand -> issued in order with memIsPf=1, each after prior memDone.
REQ-037 Fill 4 entries while WAIT, push 0x0200 -> pfDrop=1, dropCount=1; same with simultaneous pop -> accepted.
REQ-038 Queue holds 0x0300, demand 0x0300 accepted -> entry squashed, never issued as prefetch.
REQ-039 With PF_DEDUP_EN, push 0x0400 twice -> second pfDrop=1; without, both enqueued.
REQ-040 rst_n low during ISSUE -> memValid=0 immediately, queue empty, dropCount=0.
